// File: rtl/tx_am_sample_pacer.sv
// AM sample pacer: buffers AM words in a FIFO, primes it, then releases one
// sample every RATE_DIV clocks to the modulator; also latches NCO frequency words.
module tx_am_sample_pacer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 16,
  parameter int PRIME        = 8,
  parameter int RATE_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             input_am,
  input  logic                    input_am_stb,
  output logic                    input_am_ack,
  input  logic [31:0]             input_freq,
  input  logic                    input_freq_stb,
  output logic                    input_freq_ack,
  output logic [SAMPLE_WIDTH-1:0] output_sample,
  output logic                    output_sample_stb,
  output logic [31:0]             output_freq,
  output logic                    output_freq_stb,
  output logic                    output_running,
  output logic [15:0]             output_underrun_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int DIV_W  = $clog2(RATE_DIV);

  localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] PRIME_F  = FILL_W'(PRIME);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RATE_DIV - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    sample_stb_q, sample_stb_d;
  logic [31:0]             freq_q, freq_d;
  logic                    freq_stb_q, freq_stb_d;
  logic [15:0]             underrun_q, underrun_d;

  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];

  logic am_push;
  logic am_pop;
  logic freq_push;
  logic unused_am_hi;

  // Backpressure looks only at the registered fill, so a full FIFO refuses
  // a word even on the cycle it is popping.
  assign input_am_ack   = !rst && (fill_q < DEPTH_F);
  assign input_freq_ack = !rst;
  assign am_push        = input_am_stb && input_am_ack;
  assign freq_push      = input_freq_stb && input_freq_ack;
  assign unused_am_hi   = ^input_am[31:SAMPLE_WIDTH];

  // NOTE: every variable gets a default at the top of always_comb; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    am_pop       = 1'b0;
    sample_d     = sample_q;
    sample_stb_d = 1'b0;
    underrun_d   = underrun_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (fill_q >= PRIME_F) state_d = RUN;
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (fill_q != '0) begin
            am_pop       = 1'b1;
            sample_d     = mem_q[rd_ptr_q];
            sample_stb_d = 1'b1;
          end else begin
            state_d = IDLE;
            if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (am_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (am_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({am_push, am_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    freq_d     = freq_push ? input_freq : freq_q;
    freq_stb_d = freq_push;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      fill_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sample_q     <= '0;
      sample_stb_q <= 1'b0;
      freq_q       <= '0;
      freq_stb_q   <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      fill_q       <= fill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sample_q     <= sample_d;
      sample_stb_q <= sample_stb_d;
      freq_q       <= freq_d;
      freq_stb_q   <= freq_stb_d;
      underrun_q   <= underrun_d;
    end
  end

  // NOTE: the sample storage has no reset; clearing fill and pointers already
  // makes stale entries unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (am_push) mem_q[wr_ptr_q] <= input_am[SAMPLE_WIDTH-1:0];
  end

  assign output_sample         = sample_q;
  assign output_sample_stb     = sample_stb_q;
  assign output_freq           = freq_q;
  assign output_freq_stb       = freq_stb_q;
  assign output_running        = (state_q == RUN);
  assign output_underrun_count = underrun_q;

endmodule

// File: tb/tb_tx_am_sample_pacer.sv
// Directed bench for tx_am_sample_pacer: AM words go into a scoreboard queue
// when accepted and are popped and compared whenever a sample strobe appears.
module tb_tx_am_sample_pacer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_am;
  logic        input_am_stb;
  logic        input_am_ack;
  logic [31:0] input_freq;
  logic        input_freq_stb;
  logic        input_freq_ack;
  logic [15:0] output_sample;
  logic        output_sample_stb;
  logic [31:0] output_freq;
  logic        output_freq_stb;
  logic        output_running;
  logic [15:0] output_underrun_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  tx_am_sample_pacer dut (
    .clk                   (clk),
    .rst                   (rst),
    .input_am              (input_am),
    .input_am_stb          (input_am_stb),
    .input_am_ack          (input_am_ack),
    .input_freq            (input_freq),
    .input_freq_stb        (input_freq_stb),
    .input_freq_ack        (input_freq_ack),
    .output_sample         (output_sample),
    .output_sample_stb     (output_sample_stb),
    .output_freq           (output_freq),
    .output_freq_stb       (output_freq_stb),
    .output_running        (output_running),
    .output_underrun_count (output_underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every presented sample must be the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && output_sample_stb) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_sample observed=%h expected=none", output_sample);
      end else begin
        check("sample_value", {16'h0, output_sample}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_am(input logic [31:0] value);
    input_am     = value;
    input_am_stb = 1'b1;
    check("am_ack_ready", input_am_ack, 1);
    sb.push_back(value[15:0]);
    tick();
    input_am_stb = 1'b0;
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!output_sample_stb && n < 50);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (output_running && n < max) begin
      tick();
      n++;
    end
    check("back_to_idle", output_running, 0);
  endtask

  initial begin
    int n;
    int acc;
    logic exp_ack;

    rst            = 1'b1;
    input_am       = '0;
    input_am_stb   = 1'b0;
    input_freq     = '0;
    input_freq_stb = 1'b0;

    // Reset and idle
    tick();
    check("rst_am_ack", input_am_ack, 0);
    check("rst_freq_ack", input_freq_ack, 0);
    tick();
    rst = 1'b0;
    #1;
    check("idle_sample", output_sample, 0);
    check("idle_sample_stb", output_sample_stb, 0);
    check("idle_freq", output_freq, 0);
    check("idle_freq_stb", output_freq_stb, 0);
    check("idle_running", output_running, 0);
    check("idle_underrun", output_underrun_count, 0);
    check("idle_am_ack", input_am_ack, 1);
    check("idle_freq_ack", input_freq_ack, 1);

    // Priming and pacing
    for (int i = 1; i <= 7; i++) push_am(i);
    tick();
    tick();
    check("prime7_not_running", output_running, 0);
    push_am(32'h8);
    check("prime8_same_edge", output_running, 0);
    tick();
    check("prime8_running", output_running, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("pre_first_stb", output_sample_stb, 0);
    end
    tick();
    check("first_stb", output_sample_stb, 1);
    check("first_value", output_sample, 1);
    for (int p = 2; p <= 8; p++) begin
      wait_stb(n);
      check("pace_interval", n, 4);
    end

    // Underrun after draining
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("drain_no_stb", output_sample_stb, 0);
      check("drain_running", output_running, 1);
    end
    tick();
    check("underrun_no_stb", output_sample_stb, 0);
    check("underrun_hold", output_sample, 16'h0008);
    check("underrun_count1", output_underrun_count, 1);
    check("underrun_idle", output_running, 0);

    for (int i = 32'h11; i <= 32'h18; i++) push_am(i);
    wait_drain(100);
    wait_idle(20);
    check("restart_count2", output_underrun_count, 2);
    check("restart_hold", output_sample, 16'h0018);

    // Full FIFO and backpressure with pacing running underneath
    acc = 0;
    for (int e = 1; e <= 30; e++) begin
      input_am     = 32'hABCD0000 | (32'h100 + acc);
      input_am_stb = 1'b1;
      exp_ack      = (e <= 18) || (e >= 22 && ((e - 22) % 4) == 0);
      check("bp_ack", input_am_ack, exp_ack);
      if (input_am_ack) begin
        sb.push_back(16'(32'h100 + acc));
        acc++;
      end
      tick();
      if (e == 8) check("bp_idle_after_8", output_running, 0);
      if (e == 9) check("bp_run_after_9", output_running, 1);
    end
    input_am_stb = 1'b0;
    check("bp_accepted", acc, 21);

    // Frequency words while AM pacing drains
    input_freq     = 32'h12345678;
    input_freq_stb = 1'b1;
    tick();
    check("freq1_stb", output_freq_stb, 1);
    check("freq1_val", output_freq, 32'h12345678);
    input_freq = 32'h0BADBEEF;
    tick();
    check("freq2_stb", output_freq_stb, 1);
    check("freq2_val", output_freq, 32'h0BADBEEF);
    input_freq_stb = 1'b0;
    tick();
    check("freq_stb_low", output_freq_stb, 0);
    check("freq_hold", output_freq, 32'h0BADBEEF);

    wait_drain(200);
    wait_idle(20);
    check("bp_count3", output_underrun_count, 3);
    check("bp_last", output_sample, 16'(32'h100 + acc - 1));

    // Reset in the middle of RUN with five samples still buffered
    for (int i = 32'h201; i <= 32'h208; i++) push_am(i);
    n = 0;
    while (sb.size() != 5 && n < 100) begin
      tick();
      n++;
    end
    check("mid_fill5", sb.size(), 5);
    check("mid_running", output_running, 1);
    check("mid_count3", output_underrun_count, 3);
    rst = 1'b1;
    sb.delete();
    tick();
    check("mrst_sample", output_sample, 0);
    check("mrst_sample_stb", output_sample_stb, 0);
    check("mrst_freq", output_freq, 0);
    check("mrst_freq_stb", output_freq_stb, 0);
    check("mrst_running", output_running, 0);
    check("mrst_underrun", output_underrun_count, 0);
    check("mrst_am_ack", input_am_ack, 0);
    rst = 1'b0;
    #1;
    check("mrst_am_ack_rel", input_am_ack, 1);

    // Old contents must be gone: seven new words must not start pacing
    for (int i = 32'h301; i <= 32'h307; i++) push_am(i);
    tick();
    tick();
    check("mrst_prime7_idle", output_running, 0);
    push_am(32'h308);
    tick();
    check("mrst_prime8_run", output_running, 1);
    wait_drain(100);
    wait_idle(20);
    check("mrst_count1", output_underrun_count, 1);
    check("mrst_last", output_sample, 16'h0308);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
